// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared definitions for the machine-timer peripheral.
//   - register offsets inside the timer window
//   - bus FSM state type
//   - byte-lane merge helper for partial writes
package io_timer_pkg;

   localparam logic [4:0] TIMER_MTIME_LO    = 5'h00;
   localparam logic [4:0] TIMER_MTIME_HI    = 5'h04;
   localparam logic [4:0] TIMER_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] TIMER_MTIMECMP_HI = 5'h0C;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } timer_state_e;

   // Replace the bytes of cur whose sel bit is set with the matching bytes of wr.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = cur;
      for (int unsigned n = 0; n < 4; n++) begin
         if (sel[n]) res[8*n +: 8] = wr[8*n +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: free-running divider producing a one-cycle tick every
// RATIO clocks. The count runs 0..RATIO-1 and tick_o is high while it sits at
// RATIO-1; RATIO=1 ticks every cycle.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count returns to 0)
//   tick_o : one-cycle tick
module io_timer_prescaler #(
   parameter int unsigned RATIO = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   logic [CW-1:0] cnt;

   assign tick_o = (cnt == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (tick_o) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/io_timer.sv
// io_timer: machine timer peripheral (64-bit mtime / mtimecmp) on the IO bus.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   stb_i         : request strobe, held until ack_o/err_o
//   addr_i[4:0]   : byte offset in the timer window
//   data_i[31:0]  : write data
//   sel_i[3:0]    : write byte enables
//   we_i          : 1 = write, 0 = read
//   ack_o / err_o : one-cycle completion / error pulse
//   data_o[31:0]  : read data, valid with ack_o
//   timer_irq_o   : level interrupt, mtime >= mtimecmp
module io_timer
   import io_timer_pkg::*;
#(
   parameter int unsigned CLK_PERIOD_NS   = 20,
   parameter int unsigned TIMER_PERIOD_NS = 100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stb_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   output logic        ack_o,
   output logic        err_o,
   output logic [31:0] data_o,
   output logic        timer_irq_o
);

   localparam int unsigned RATIO = TIMER_PERIOD_NS / CLK_PERIOD_NS;

   timer_state_e state;
   logic [63:0]  mtime, mtimecmp;
   logic [63:0]  mtime_nxt, mtimecmp_nxt;
   logic         ack_q, err_q;
   logic         tick;
   logic         accept, bad_addr;
   logic [31:0]  cur_word, merged;

   io_timer_prescaler #(.RATIO(RATIO)) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   assign accept   = (state == IDLE) && stb_i;
   assign bad_addr = (addr_i[1:0] != 2'b00) || addr_i[4];

   always_comb begin
      cur_word = '0;
      case (addr_i)
         TIMER_MTIME_LO:    cur_word = mtime[31:0];
         TIMER_MTIME_HI:    cur_word = mtime[63:32];
         TIMER_MTIMECMP_LO: cur_word = mtimecmp[31:0];
         TIMER_MTIMECMP_HI: cur_word = mtimecmp[63:32];
         default:           cur_word = '0;
      endcase
   end

   assign merged = merge_bytes(cur_word, data_i, sel_i);

   // An mtime write overrides the increment (the tick is dropped); a
   // mtimecmp write leaves the increment alone.
   always_comb begin
      mtime_nxt    = tick ? mtime + 64'd1 : mtime;
      mtimecmp_nxt = mtimecmp;
      if (accept && !bad_addr && we_i) begin
         case (addr_i)
            TIMER_MTIME_LO:    mtime_nxt = {mtime[63:32], merged};
            TIMER_MTIME_HI:    mtime_nxt = {merged, mtime[31:0]};
            TIMER_MTIMECMP_LO: mtimecmp_nxt[31:0]  = merged;
            TIMER_MTIMECMP_HI: mtimecmp_nxt[63:32] = merged;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         mtime       <= '0;
         mtimecmp    <= '1;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         data_o      <= '0;
         timer_irq_o <= 1'b0;
      end else begin
         mtime       <= mtime_nxt;
         mtimecmp    <= mtimecmp_nxt;
         timer_irq_o <= (mtime_nxt >= mtimecmp_nxt);
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         data_o      <= '0;
         case (state)
            IDLE: begin
               if (stb_i) begin
                  state <= RESP;
                  if (bad_addr) begin
                     err_q <= 1'b1;
                  end else begin
                     ack_q <= 1'b1;
                     if (!we_i) data_o <= cur_word;
                  end
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A reset arriving during the response cycle cancels the pending pulse;
   // the master re-issues the request.
   assign ack_o = ack_q & ~rst_i;
   assign err_o = err_q & ~rst_i;

endmodule

// File: tb/tb_io_timer.sv
`timescale 1ns/1ps
module tb_io_timer;

   localparam int unsigned CLK_NS = 20;
   localparam int unsigned TMR_NS = 100;
   localparam int unsigned R      = TMR_NS / CLK_NS;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stb_i = 1'b0;
   logic [4:0]  addr_i = '0;
   logic [31:0] data_i = '0;
   logic [3:0]  sel_i = '0;
   logic        we_i = 1'b0;
   logic        ack_o, err_o, timer_irq_o;
   logic [31:0] data_o;

   int checks = 0;
   int failures = 0;
   int ack_count = 0;

   io_timer #(.CLK_PERIOD_NS(CLK_NS), .TIMER_PERIOD_NS(TMR_NS)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .addr_i(addr_i),
      .data_i(data_i), .sel_i(sel_i), .we_i(we_i), .ack_o(ack_o),
      .err_o(err_o), .data_o(data_o), .timer_irq_o(timer_irq_o)
   );

   always #(CLK_NS/2) clk_i = ~clk_i;

   // ---------------- reference model ----------------
   // Cycle count since reset decides ticks; a response is pending for the
   // one cycle after an accepted request.
   bit          m_valid = 0;
   int unsigned m_cyc = 0;
   bit          m_busy = 0;
   logic [63:0] m_mt = '0, m_cmp = '1;
   bit          e_ack = 0, e_err = 0, e_irq = 0;
   logic [31:0] e_data = '0;

   always @(posedge clk_i) begin : model
      logic [63:0] mt, cmp;
      logic [31:0] cur, wr;
      bit          tk, acc, bad, mt_wr, n_ack, n_err;
      logic [31:0] n_data;
      int unsigned word;
      if (rst_i) begin
         m_valid <= 1; m_cyc <= 0; m_busy <= 0;
         m_mt <= '0; m_cmp <= '1;
         e_ack <= 0; e_err <= 0; e_irq <= 0; e_data <= '0;
      end else if (m_valid) begin
         mt = m_mt; cmp = m_cmp;
         tk = ((m_cyc % R) == R - 1);
         acc = stb_i && !m_busy;
         n_ack = 0; n_err = 0; n_data = '0; mt_wr = 0;
         if (acc) begin
            bad = (addr_i % 4 != 0) || (addr_i >= 16);
            if (bad) n_err = 1;
            else begin
               n_ack = 1;
               word = addr_i / 4;
               case (word)
                  0: cur = mt[31:0];
                  1: cur = mt[63:32];
                  2: cur = cmp[31:0];
                  default: cur = cmp[63:32];
               endcase
               if (!we_i) n_data = cur;
               else begin
                  wr = cur;
                  for (int b = 0; b < 4; b++)
                     if (sel_i[b]) wr[8*b +: 8] = data_i[8*b +: 8];
                  case (word)
                     0: begin mt[31:0] = wr; mt_wr = 1; end
                     1: begin mt[63:32] = wr; mt_wr = 1; end
                     2: cmp[31:0] = wr;
                     default: cmp[63:32] = wr;
                  endcase
               end
            end
         end
         if (tk && !mt_wr) mt = mt + 1;
         m_mt <= mt; m_cmp <= cmp;
         m_cyc <= m_cyc + 1;
         m_busy <= acc;
         e_ack <= n_ack; e_err <= n_err; e_data <= n_data;
         e_irq <= (mt >= cmp);
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      if (m_valid) begin
         checks++;
         if (ack_o !== (e_ack && !rst_i)) begin
            failures++;
            $display("FAIL ack_o t=%0t got=%b want=%b", $time, ack_o, e_ack && !rst_i);
         end
         checks++;
         if (err_o !== (e_err && !rst_i)) begin
            failures++;
            $display("FAIL err_o t=%0t got=%b want=%b", $time, err_o, e_err && !rst_i);
         end
         checks++;
         if (timer_irq_o !== e_irq) begin
            failures++;
            $display("FAIL timer_irq_o t=%0t got=%b want=%b", $time, timer_irq_o, e_irq);
         end
         if ((e_ack || e_err) && !rst_i) begin
            checks++;
            if (data_o !== e_data) begin
               failures++;
               $display("FAIL data_o t=%0t got=%h want=%h", $time, data_o, e_data);
            end
         end
         if (ack_o === 1'b1) ack_count++;
      end
   end

   // ---------------- helpers ----------------
   task automatic txn(input bit we, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output bit ge);
      bit done = 0;
      int unsigned n = 0;
      rd = '0; ge = 0;
      we_i = we; addr_i = a; data_i = d; sel_i = s; stb_i = 1'b1;
      while (!done && n < 4) begin
         @(posedge clk_i); #1; n++;
         if (ack_o || err_o) begin done = 1; rd = data_o; ge = err_o; end
      end
      stb_i = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL txn_timeout addr=%h got=no_response want=ack_or_err", a);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic chk_range(input string name, input logic [31:0] got,
                            input logic [31:0] lo, input logic [31:0] hi);
      checks++;
      if (got < lo || got > hi) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
      end
   endtask

   // Leave the next posedge as a tick edge (model's view of the prescaler).
   task automatic align_tick();
      int unsigned n = 0;
      do begin @(posedge clk_i); #1; n++; end
      while ((m_cyc % R) != R - 1 && n < 2 * R);
   endtask

   typedef struct {
      bit          we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  sel;
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      bit ge;
      int acks0;
      int unsigned n;

      tbl[0]  = '{0, 5'h08, 32'h0,         4'h0, 0, 32'hFFFF_FFFF};
      tbl[1]  = '{0, 5'h0C, 32'h0,         4'h0, 0, 32'hFFFF_FFFF};
      tbl[2]  = '{0, 5'h02, 32'h0,         4'h0, 1, 32'h0};
      tbl[3]  = '{0, 5'h14, 32'h0,         4'h0, 1, 32'h0};
      tbl[4]  = '{1, 5'h10, 32'h0,         4'hF, 1, 32'h0};
      tbl[5]  = '{1, 5'h0D, 32'h0,         4'hF, 1, 32'h0};
      tbl[6]  = '{0, 5'h0C, 32'h0,         4'h0, 0, 32'hFFFF_FFFF};
      tbl[7]  = '{1, 5'h0C, 32'h1234_5678, 4'h0, 0, 32'h0};
      tbl[8]  = '{0, 5'h0C, 32'h0,         4'h0, 0, 32'hFFFF_FFFF};
      tbl[9]  = '{1, 5'h0C, 32'hA5A5_0000, 4'hC, 0, 32'h0};
      tbl[10] = '{0, 5'h0C, 32'h0,         4'h0, 0, 32'hA5A5_FFFF};
      tbl[11] = '{1, 5'h08, 32'h0,         4'h1, 0, 32'h0};
      tbl[12] = '{0, 5'h08, 32'h0,         4'h0, 0, 32'hFFFF_FF00};
      tbl[13] = '{0, 5'h04, 32'h0,         4'h0, 0, 32'h0};
      tbl[14] = '{1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 0, 32'h0};
      tbl[15] = '{1, 5'h08, 32'hFFFF_FFFF, 4'hF, 0, 32'h0};
      tbl[16] = '{0, 5'h0C, 32'h0,         4'h0, 0, 32'hFFFF_FFFF};

      // Reset
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_irq", {31'b0, timer_irq_o}, 32'h0);
      chk("reset_ack", {30'b0, ack_o, err_o}, 32'h0);

      // mtime after ~50 clocks at RATIO=5
      repeat (49) @(posedge clk_i);
      #1 txn(0, 5'h00, 0, 0, rd, ge);
      chk_range("mtime_50clk", rd, 32'd9, 32'd11);

      // Directed register vectors
      for (int i = 0; i < NV; i++) begin
         txn(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel, rd, ge);
         chk($sformatf("vec%0d_err", i), {31'b0, ge}, {31'b0, tbl[i].exp_err});
         if (!tbl[i].we) chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      end

      // LO->HI carry
      txn(1, 5'h00, 32'hFFFF_FFFE, 4'hF, rd, ge);
      txn(1, 5'h04, 32'h0, 4'hF, rd, ge);
      repeat (3 * R) @(posedge clk_i);
      #1 txn(0, 5'h04, 0, 0, rd, ge);
      chk("carry_hi", rd, 32'h1);
      txn(0, 5'h00, 0, 0, rd, ge);
      chk_range("carry_lo", rd, 32'd1, 32'd3);

      // Interrupt rise and fall
      txn(1, 5'h0C, 32'h0, 4'hF, rd, ge);
      txn(1, 5'h00, 32'd90, 4'hF, rd, ge);
      txn(1, 5'h04, 32'h0, 4'hF, rd, ge);
      txn(1, 5'h08, 32'd100, 4'hF, rd, ge);
      chk("irq_below_cmp", {31'b0, timer_irq_o}, 32'h0);
      n = 0;
      while (!timer_irq_o && n < 200) begin @(negedge clk_i); n++; end
      chk("irq_rise_seen", {31'b0, timer_irq_o}, 32'h1);
      @(posedge clk_i); #1;
      txn(1, 5'h08, 32'd200, 4'hF, rd, ge);
      chk("irq_fall", {31'b0, timer_irq_o}, 32'h0);

      // Byte-lane write to MTIME_LO landing on a tick edge
      txn(1, 5'h04, 32'h55, 4'hF, rd, ge);
      align_tick();
      txn(1, 5'h00, 32'h1234_5678, 4'hF, rd, ge);
      align_tick();
      txn(1, 5'h00, 32'h0000_AB00, 4'b0010, rd, ge);
      txn(0, 5'h00, 0, 0, rd, ge);
      chk("merge_lo", rd, 32'h1234_AB78);
      txn(0, 5'h04, 0, 0, rd, ge);
      chk("merge_hi", rd, 32'h55);

      // Strobe held across the response cycle: one ack only
      @(posedge clk_i); #1;
      acks0 = ack_count;
      we_i = 0; addr_i = 5'h08; stb_i = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      stb_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 chk("held_stb_acks", ack_count - acks0, 32'd1);

      // Reset during the response cycle
      we_i = 1; addr_i = 5'h0C; data_i = 32'h0; sel_i = 4'hF; stb_i = 1'b1;
      @(posedge clk_i); #1;
      stb_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_in_resp_ack", {30'b0, ack_o, err_o}, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1 txn(0, 5'h00, 0, 0, rd, ge);
      chk("rst_prescaler_pre", rd, 32'h0);
      txn(0, 5'h00, 0, 0, rd, ge);
      chk("rst_prescaler_post", rd, 32'h1);
      txn(0, 5'h0C, 0, 0, rd, ge);
      chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);

      // Randomized traffic checked by the model
      for (int i = 0; i < 200; i++) begin
         logic [4:0] a;
         logic [31:0] d;
         if ($urandom_range(0, 7) == 0) a = 5'($urandom_range(0, 31));
         else a = 5'($urandom_range(0, 3) * 4);
         d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
         txn($urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)), rd, ge);
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         #1;
      end

      repeat (3) @(posedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
